// File: rtl/cache_nway_wb_if.sv
// Processor and block-memory bus of the N-way write-back data cache.
// The slave modport is the cache side; master is the pipeline plus memory side.
interface cache_nway_wb_if #(
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned WORDS  = 4
);
   localparam int unsigned BLK_W = ADDR_W - $clog2(WORDS);

   logic              proc_read;
   logic              proc_write;
   logic [ADDR_W-1:0] proc_addr;
   logic [31:0]       proc_wdata;
   logic [31:0]       proc_rdata;
   logic              proc_stall;
   logic              mem_read;
   logic              mem_write;
   logic [BLK_W-1:0]  mem_addr;
   logic [32*WORDS-1:0] mem_wdata;
   logic [32*WORDS-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate data cache with round-robin replacement.
// Define CACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_nway_wb #(
   parameter int unsigned WAYS   = 2,
   parameter int unsigned SETS   = 4,
   parameter int unsigned WORDS  = 4,
   parameter int unsigned ADDR_W = 30
) (
   input  logic        clk,
   input  logic        proc_reset,
   cache_nway_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WRITE_BACK = 2'd1;
   localparam logic [1:0] ALLOCATE   = 2'd2;

   logic [31:0]      data_q  [SETS][WAYS][WORDS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [WAY_W-1:0] rr_q    [SETS];
   logic [1:0]       st_q, st_d;
   logic [WAY_W-1:0] victim_q;

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             req, hit;
   logic [WAY_W-1:0] hit_way, vsel, wb_way;
   logic [32*WORDS-1:0] wb_blk;

   assign off = bus.proc_addr[OFF_W-1:0];
   assign idx = bus.proc_addr[OFF_W +: IDX_W];
   assign tag = bus.proc_addr[ADDR_W-1 -: TAG_W];
   assign req = bus.proc_read | bus.proc_write;

   // Lookup and victim choice: lowest invalid way wins over the round-robin pointer.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      vsel    = rr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) vsel = WAY_W'(w);
      end
   end

   assign wb_way = (st_q == IDLE) ? vsel : victim_q;

   always_comb begin
      for (int k = 0; k < WORDS; k++) wb_blk[k*32 +: 32] = data_q[idx][wb_way][k];
   end

   always_comb begin
      st_d           = st_q;
      bus.proc_stall = 1'b0;
      bus.proc_rdata = '0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      if (!proc_reset) begin
         case (st_q)
            IDLE: begin
               if (req && hit) begin
                  bus.proc_rdata = data_q[idx][hit_way][off];
               end else if (req) begin
                  bus.proc_stall = 1'b1;
                  if (valid_q[idx][vsel] && dirty_q[idx][vsel]) begin
                     bus.mem_write = 1'b1;
                     bus.mem_addr  = {tag_q[idx][vsel], idx};
                     bus.mem_wdata = wb_blk;
                     st_d          = WRITE_BACK;
                  end else begin
                     bus.mem_read = 1'b1;
                     bus.mem_addr = bus.proc_addr[ADDR_W-1:OFF_W];
                     st_d         = ALLOCATE;
                  end
               end
            end
            WRITE_BACK: begin
               bus.proc_stall = 1'b1;
               if (bus.mem_ready) begin
                  bus.mem_read = 1'b1;
                  bus.mem_addr = bus.proc_addr[ADDR_W-1:OFF_W];
                  st_d         = ALLOCATE;
               end else begin
                  bus.mem_write = 1'b1;
                  bus.mem_addr  = {tag_q[idx][victim_q], idx};
                  bus.mem_wdata = wb_blk;
               end
            end
            ALLOCATE: begin
               bus.proc_stall = 1'b1;
               bus.mem_read   = 1'b1;
               bus.mem_addr   = bus.proc_addr[ADDR_W-1:OFF_W];
               if (bus.mem_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         st_q     <= IDLE;
         victim_q <= '0;
         valid_q  <= '{default: '0};
         dirty_q  <= '{default: '0};
         rr_q     <= '{default: '0};
      end else begin
         st_q <= st_d;
         if (st_q == IDLE && req && !hit) victim_q <= vsel;
         if (st_q == IDLE && bus.proc_write && hit) dirty_q[idx][hit_way] <= 1'b1;
         if (st_q == ALLOCATE && bus.mem_ready) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            if (victim_q == rr_q[idx]) begin
               rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
            end
         end
      end
   end

   // Data and tags need no reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (!proc_reset) begin
         if (st_q == IDLE && bus.proc_write && hit) begin
            data_q[idx][hit_way][off] <= bus.proc_wdata;
         end else if (st_q == ALLOCATE && bus.mem_ready) begin
            for (int k = 0; k < WORDS; k++) data_q[idx][victim_q][k] <= bus.mem_rdata[k*32 +: 32];
            tag_q[idx][victim_q] <= tag;
         end
      end
   end

`ifdef CACHE_PERF_CNT_EN
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (st_q == IDLE && req) begin
         if (hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
         if (!hit && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`else
   // No performance counters in this build.
`endif
endmodule
